// File: rtl/cfs_aligner_regs_if.sv
// APB bus bundle between the interconnect (master) and the Aligner register block (slave).
// Carries only the handshake/data wires; pclk and preset_n stay as plain ports.
interface cfs_aligner_regs_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/cfs_aligner_regs.sv
// Aligner APB registers: CTRL, saturating drop counter, sticky IRQ with mask; irq output is registered.
// ACCESS completes after WAIT_STATES stall cycles (pready low); prdata/pslverr are combinational during pready.
module cfs_aligner_regs #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                 pclk,
  input  logic                 preset_n,
  cfs_aligner_regs_if.slave    apb,
  output logic [2:0]           ctrl_size,
  output logic [1:0]           ctrl_offset,
  output logic                 ctrl_clr,
  input  logic                 drop_evt,
  input  logic [4:0]           irq_evt,
  output logic                 irq
);

  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'('h0000);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'('h000C);
  localparam logic [ADDR_WIDTH-1:0] A_IRQEN  = ADDR_WIDTH'('h00F0);
  localparam logic [ADDR_WIDTH-1:0] A_IRQ    = ADDR_WIDTH'('h00F4);

  logic [3:0]            wait_cnt;
  logic [7:0]            cnt_drop;
  logic [4:0]            irqen_r;
  logic [4:0]            irq_r;
  logic [ADDR_WIDTH-1:0] addr_w;
  logic                  access;
  logic                  ready;
  logic                  sel_ctrl, sel_status, sel_irqen, sel_irq, unmapped;
  logic [2:0]            wsize;
  logic [1:0]            woff;
  logic                  ctrl_bad;
  logic                  err;
  logic                  commit;
  logic [4:0]            irq_clr;
  logic [DATA_WIDTH-1:0] rdata;

  assign access = apb.psel & apb.penable;
  // Gating with preset_n keeps pready low while reset is held mid-transfer.
  assign ready  = preset_n & access & (wait_cnt == 4'(WAIT_STATES));

  assign addr_w     = {apb.paddr[ADDR_WIDTH-1:2], 2'b00};
  assign sel_ctrl   = (addr_w == A_CTRL);
  assign sel_status = (addr_w == A_STATUS);
  assign sel_irqen  = (addr_w == A_IRQEN);
  assign sel_irq    = (addr_w == A_IRQ);
  assign unmapped   = ~(sel_ctrl | sel_status | sel_irqen | sel_irq);

  assign wsize    = apb.pwdata[2:0];
  assign woff     = apb.pwdata[9:8];
  assign ctrl_bad = (wsize == 3'd0) | (wsize == 3'd3) | (wsize > 3'd4) |
                    (({2'b00, woff} + {1'b0, wsize}) > 4'd4);

  assign err = ready & (unmapped |
                        (apb.pwrite & sel_status) |
                        (apb.pwrite & sel_ctrl & ctrl_bad));
  assign commit  = ready & apb.pwrite & ~err;
  assign irq_clr = (commit & sel_irq) ? apb.pwdata[4:0] : 5'd0;

  always_comb begin
    rdata = '0;
    if (sel_ctrl)
      rdata = DATA_WIDTH'({22'd0, ctrl_offset, 5'd0, ctrl_size});
    else if (sel_status)
      rdata = DATA_WIDTH'({24'd0, cnt_drop});
    else if (sel_irqen)
      rdata = DATA_WIDTH'({27'd0, irqen_r});
    else if (sel_irq)
      rdata = DATA_WIDTH'({27'd0, irq_r});
  end

  assign apb.pready  = ready;
  assign apb.pslverr = err;
  assign apb.prdata  = (ready & ~apb.pwrite) ? rdata : '0;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt    <= 4'd0;
      ctrl_size   <= 3'd1;
      ctrl_offset <= 2'd0;
      ctrl_clr    <= 1'b0;
      cnt_drop    <= 8'd0;
      irqen_r     <= 5'd0;
      irq_r       <= 5'd0;
      irq         <= 1'b0;
    end else begin
      wait_cnt <= (access & ~ready) ? wait_cnt + 4'd1 : 4'd0;

      if (commit & sel_ctrl) begin
        ctrl_size   <= wsize;
        ctrl_offset <= woff;
      end
      ctrl_clr <= commit & sel_ctrl & apb.pwdata[16];

      // A pending clear wins over a drop arriving in the same cycle.
      if (ctrl_clr)
        cnt_drop <= 8'd0;
      else if (drop_evt && cnt_drop != 8'hFF)
        cnt_drop <= cnt_drop + 8'd1;

      if (commit & sel_irqen)
        irqen_r <= apb.pwdata[4:0];

      irq_r <= (irq_r & ~irq_clr) | irq_evt;
      irq   <= |(irq_r & irqen_r);
    end
  end

endmodule

// File: tb/tb_cfs_aligner_regs.sv
// Directed bench for cfs_aligner_regs with WAIT_STATES=2: vector table plus drop/IRQ/reset sequences.
module tb_cfs_aligner_regs;

  localparam int WS = 2;

  logic       pclk;
  logic       preset_n;
  logic [2:0] ctrl_size;
  logic [1:0] ctrl_offset;
  logic       ctrl_clr;
  logic       drop_evt;
  logic [4:0] irq_evt;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  cfs_aligner_regs_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  cfs_aligner_regs #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .WAIT_STATES(WS)) dut (
    .pclk        (pclk),
    .preset_n    (preset_n),
    .apb         (bus),
    .ctrl_size   (ctrl_size),
    .ctrl_offset (ctrl_offset),
    .ctrl_clr    (ctrl_clr),
    .drop_evt    (drop_evt),
    .irq_evt     (irq_evt),
    .irq         (irq)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        chk_ctrl;
    logic [2:0]  exp_size;
    logic [1:0]  exp_off;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One APB transfer; evt is driven on irq_evt during the completing ACCESS cycle.
  task automatic apb(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                     input logic [4:0] evt, output logic [31:0] rd, output logic err,
                     output int waits);
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wd;
    @(negedge pclk);
    bus.penable = 1'b1;
    #1;
    waits = 0;
    while (bus.pready !== 1'b1 && waits < 16) begin
      @(negedge pclk); #1;
      waits++;
    end
    rd  = bus.prdata;
    err = bus.pslverr;
    irq_evt = evt;
    @(posedge pclk); #1;
    irq_evt = 5'd0;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic err; int w;
    apb(1'b0, addr, 32'd0, 5'd0, rd, err, w);
    chk({nm, " rdata"}, rd, exp);
    chk({nm, " err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic wr_ok(input string nm, input logic [15:0] addr, input logic [31:0] wd,
                       input logic [4:0] evt);
    logic [31:0] rd; logic err; int w;
    apb(1'b1, addr, wd, evt, rd, err, w);
    chk({nm, " err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        err;
    int          w;

    //           wr    addr      wdata         rdata         err   chk   size  off
    vecs[0]  = '{1'b0, 16'h0000, 32'h0,        32'h0000_0001, 1'b0, 1'b0, 3'd0, 2'd0};
    vecs[1]  = '{1'b0, 16'h00F4, 32'h0,        32'h0,         1'b0, 1'b0, 3'd0, 2'd0};
    vecs[2]  = '{1'b0, 16'h000C, 32'h0,        32'h0,         1'b0, 1'b0, 3'd0, 2'd0};
    vecs[3]  = '{1'b0, 16'h00F0, 32'h0,        32'h0,         1'b0, 1'b0, 3'd0, 2'd0};
    vecs[4]  = '{1'b1, 16'h0000, 32'h0000_0102, 32'h0,        1'b0, 1'b1, 3'd2, 2'd1};
    vecs[5]  = '{1'b0, 16'h0000, 32'h0,        32'h0000_0102, 1'b0, 1'b0, 3'd0, 2'd0};
    vecs[6]  = '{1'b1, 16'h0000, 32'h0000_0104, 32'h0,        1'b1, 1'b1, 3'd2, 2'd1};
    vecs[7]  = '{1'b1, 16'h000C, 32'h0000_0055, 32'h0,        1'b1, 1'b0, 3'd0, 2'd0};
    vecs[8]  = '{1'b0, 16'h0040, 32'h0,        32'h0,         1'b1, 1'b0, 3'd0, 2'd0};
    vecs[9]  = '{1'b1, 16'h0000, 32'h0000_0000, 32'h0,        1'b1, 1'b1, 3'd2, 2'd1};
    vecs[10] = '{1'b1, 16'h0000, 32'h0000_0003, 32'h0,        1'b1, 1'b1, 3'd2, 2'd1};
    vecs[11] = '{1'b1, 16'h0000, 32'h0000_0005, 32'h0,        1'b1, 1'b1, 3'd2, 2'd1};
    vecs[12] = '{1'b1, 16'h0000, 32'h0000_0302, 32'h0,        1'b1, 1'b1, 3'd2, 2'd1};
    vecs[13] = '{1'b1, 16'h0000, 32'h0000_0004, 32'h0,        1'b0, 1'b1, 3'd4, 2'd0};
    vecs[14] = '{1'b1, 16'h0000, 32'hFFFF_0301, 32'h0,        1'b0, 1'b1, 3'd1, 2'd3};
    vecs[15] = '{1'b0, 16'h0003, 32'h0,        32'h0000_0301, 1'b0, 1'b0, 3'd0, 2'd0};
    vecs[16] = '{1'b1, 16'h00F0, 32'hFFFF_FFFF, 32'h0,        1'b0, 1'b0, 3'd0, 2'd0};
    vecs[17] = '{1'b0, 16'h00F2, 32'h0,        32'h0000_001F, 1'b0, 1'b0, 3'd0, 2'd0};
    vecs[18] = '{1'b1, 16'h0100, 32'h0000_0001, 32'h0,        1'b1, 1'b0, 3'd0, 2'd0};
    vecs[19] = '{1'b1, 16'h00F0, 32'h0000_0001, 32'h0,        1'b0, 1'b0, 3'd0, 2'd0};
    vecs[20] = '{1'b1, 16'h0000, 32'h0000_0102, 32'h0,        1'b0, 1'b1, 3'd2, 2'd1};

    preset_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    drop_evt = 1'b0; irq_evt = 5'd0;

    repeat (2) @(negedge pclk);
    chk("rst pready",   {31'd0, bus.pready},  32'd0);
    chk("rst prdata",   bus.prdata,           32'd0);
    chk("rst pslverr",  {31'd0, bus.pslverr}, 32'd0);
    chk("rst size",     {29'd0, ctrl_size},   32'd1);
    chk("rst offset",   {30'd0, ctrl_offset}, 32'd0);
    chk("rst ctrl_clr", {31'd0, ctrl_clr},    32'd0);
    chk("rst irq",      {31'd0, irq},         32'd0);
    preset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 5'd0, rd, err, w);
      chk($sformatf("vec%0d waits", i), w, WS);
      chk($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      if (vecs[i].chk_ctrl) begin
        chk($sformatf("vec%0d size", i), {29'd0, ctrl_size}, {29'd0, vecs[i].exp_size});
        chk($sformatf("vec%0d offset", i), {30'd0, ctrl_offset}, {30'd0, vecs[i].exp_off});
      end
    end

    // Drop counter saturation, clear pulse, and clear winning over a same-cycle drop.
    @(negedge pclk); drop_evt = 1'b1;
    repeat (300) @(negedge pclk);
    drop_evt = 1'b0;
    rd_chk("drop sat", 16'h000C, 32'h0000_00FF);
    wr_ok("clr wr", 16'h0000, 32'h0001_0102, 5'd0);
    chk("clr pulse hi", {31'd0, ctrl_clr}, 32'd1);
    drop_evt = 1'b1;
    @(posedge pclk); #1;
    drop_evt = 1'b0;
    chk("clr pulse lo", {31'd0, ctrl_clr}, 32'd0);
    chk("clr size kept", {29'd0, ctrl_size}, 32'd2);
    rd_chk("drop cleared", 16'h000C, 32'h0);
    @(negedge pclk); drop_evt = 1'b1;
    @(negedge pclk); drop_evt = 1'b0;
    rd_chk("drop one", 16'h000C, 32'h0000_0001);

    // Sticky IRQ, masked output with one-cycle latency, set-beats-clear.
    @(negedge pclk); irq_evt = 5'b00001;
    @(negedge pclk); irq_evt = 5'd0;
    chk("irq latency", {31'd0, irq}, 32'd0);
    @(negedge pclk);
    chk("irq asserted", {31'd0, irq}, 32'd1);
    rd_chk("irq reg set", 16'h00F4, 32'h0000_0001);
    wr_ok("irq w1c+evt", 16'h00F4, 32'h0000_0001, 5'b00001);
    rd_chk("irq set wins", 16'h00F4, 32'h0000_0001);
    chk("irq still hi", {31'd0, irq}, 32'd1);
    wr_ok("irq w1c", 16'h00F4, 32'h0000_0001, 5'd0);
    rd_chk("irq cleared", 16'h00F4, 32'h0);
    chk("irq low", {31'd0, irq}, 32'd0);
    @(negedge pclk); irq_evt = 5'b00010;
    @(negedge pclk); irq_evt = 5'd0;
    repeat (2) @(negedge pclk);
    chk("irq masked", {31'd0, irq}, 32'd0);
    rd_chk("irq bit1", 16'h00F4, 32'h0000_0002);
    wr_ok("irq w1c bit1", 16'h00F4, 32'h0000_0002, 5'd0);

    // Reset during the completing ACCESS cycle of a legal CTRL write.
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 16'h0000; bus.pwdata = 32'h0000_0004;
    @(negedge pclk); bus.penable = 1'b1; #1;
    w = 0;
    while (bus.pready !== 1'b1 && w < 16) begin
      @(negedge pclk); #1;
      w++;
    end
    chk("rstx waits", w, WS);
    preset_n = 1'b0;
    #1;
    chk("rstx pready", {31'd0, bus.pready}, 32'd0);
    chk("rstx size", {29'd0, ctrl_size}, 32'd1);
    @(negedge pclk);
    bus.psel = 1'b0; bus.penable = 1'b0;
    @(negedge pclk); preset_n = 1'b1;
    @(negedge pclk);
    chk("rstx size after", {29'd0, ctrl_size}, 32'd1);
    chk("rstx off after", {30'd0, ctrl_offset}, 32'd0);
    rd_chk("rstx ctrl", 16'h0000, 32'h0000_0001);
    rd_chk("rstx irqen", 16'h00F0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cfs_aligner_regs.md
Name: cfs_aligner_regs

Overview:
- APB slave register block for the Aligner; directly consumes the APB bus (psel/penable/pwrite/paddr/pwdata → pready/prdata/pslverr).
- Holds the control register driving the alignment datapath, a saturating drop counter, and a sticky interrupt block with enable mask.
- Sits between the APB interconnect and the Aligner core.

Parameters:
- ADDR_WIDTH, 16, APB address width.
- DATA_WIDTH, 32, APB data width; fixed at 32 for this register map.
- WAIT_STATES, 0, number of ACCESS cycles with pready=0 before pready=1 (0..15).

Ports:
- pclk  in  1  APB clock.
- preset_n  in  1  Reset, asynchronous assert, active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_WIDTH  Byte address; paddr[1:0] ignored (word aligned).
- pwdata  in  DATA_WIDTH  Write data.
- pready  out  1  Transfer complete.
- prdata  out  DATA_WIDTH  Read data; valid while pready=1 on a read.
- pslverr  out  1  Error; valid only while pready=1.
- ctrl_size  out  3  CTRL.SIZE to core.
- ctrl_offset  out  2  CTRL.OFFSET to core.
- ctrl_clr  out  1  One-cycle pulse on CTRL.CLR write.
- drop_evt  in  1  Core dropped-data event, one pulse per drop.
- irq_evt  in  5  Core interrupt events (rx_full, rx_empty, tx_full, tx_empty, max_drop).
- irq  out  1  Interrupt = |(IRQ & IRQEN).

Behaviour:
- Reset (preset_n=0, async): pready=0, prdata=0, pslverr=0, SIZE=1, OFFSET=0, ctrl_clr=0, CNT_DROP=0, IRQEN=0, IRQ=0, irq=0, wait counter=0.
- Phases: SETUP = psel & !penable; ACCESS = psel & penable. Wait counter increments every ACCESS cycle with pready=0 and clears to 0 outside ACCESS and on completion.
- pready = ACCESS & (wait_cnt == WAIT_STATES); 0 in all other cycles. WAIT_STATES=0 → ACCESS completes in its first cycle.
- Writes commit on the rising edge ending the ACCESS cycle with pready=1. prdata and pslverr are combinational, valid only while pready=1; prdata=0 otherwise.
- Register map (word offsets):
  - 0x0000 CTRL RW: SIZE[2:0], OFFSET[9:8]. CLR[16] is write-only, reads 0, and drives ctrl_clr high for exactly the cycle after commit. All other bits read 0.
  - 0x000C STATUS RO: CNT_DROP[7:0]. Other bits read 0.
  - 0x00F0 IRQEN RW: bits[4:0].
  - 0x00F4 IRQ RW1C: bits[4:0].
- CTRL legality: a write is illegal if SIZE==0, SIZE==3, SIZE>4, or OFFSET+SIZE>4. An illegal write sets pslverr=1 and updates no CTRL field; CLR is also ignored.
- Write to STATUS → pslverr=1, no effect.
- Any access to an unmapped address → pslverr=1, prdata=0.
- CNT_DROP increments on drop_evt and saturates at 255. ctrl_clr zeroes it in the cycle it is high. Clear beats a simultaneous drop_evt (result 0).
- IRQ[i] sets on irq_evt[i]=1 and clears on a committed write with pwdata[i]=1. Set beats a simultaneous clear. irq is registered from the IRQ/IRQEN state (one-cycle latency after either changes).
- psel dropped mid-transfer: the transfer is abandoned with no commit and the wait counter clears.
- penable=1 without a preceding SETUP cycle: still treated as ACCESS, since decoding uses psel & penable only.
- Reset asserted mid-transfer: all state returns to reset values immediately; the interrupted write does not commit.

Test Plan:
- Reset, then read 0x0000 → prdata=0x0000_0001, pslverr=0. Read 0x00F4 → 0. irq=0.
- WAIT_STATES=2: write 0x0000 = 0x0000_0102 → pready low for 2 ACCESS cycles, high on the 3rd. ctrl_size=2, ctrl_offset=1, pslverr=0.
- Write CTRL SIZE=4 OFFSET=1 (0x0000_0104) → pslverr=1, ctrl_size/offset unchanged. Write 0x000C → pslverr=1. Read 0x0040 → pslverr=1, prdata=0.
- Pulse drop_evt 300 times → STATUS reads 255. Write CTRL 0x0001_0001 → ctrl_clr high one cycle, STATUS reads 0. drop_evt in the ctrl_clr cycle → count stays 0.
- IRQEN=0x01, pulse irq_evt[0] → IRQ=0x01 and irq=1 one cycle later. Write IRQ=0x01 with irq_evt[0] in the same cycle → IRQ stays 1. Write IRQ=0x01 alone → IRQ=0, irq=0.
- Assert preset_n=0 during the ACCESS of a CTRL write → no commit, pready=0, CTRL=reset value after release.
